// File: rtl/mspc_v_pkg.sv
// Shared opcode constants, result kinds and FSM states for the ALU issue stage.
// The helpers here classify a 4-bit ALU opcode.
package mspc_v_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BLT  = 4'b0111;
  localparam logic [3:0] NOP_SEL = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_BOOL = 2'd1,
    KIND_NOP  = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARK,
    ST_DRIVE,
    ST_RESULT
  } state_e;

  function automatic kind_e op_class(input logic [3:0] sel);
    case (sel)
      OP_BEQ, OP_BLT:                                return KIND_BOOL;
      4'b1000, 4'b1001, 4'b1101, 4'b1110, 4'b1111:   return KIND_NOP;
      default:                                       return KIND_NUM;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
  endfunction

endpackage

// File: rtl/mspc_v_alu_issue.sv
// Issue stage in front of the 64-bit ALU: parks the opcode at NOP_SEL before
// every op so the combinational ALU always sees a transition, then captures.
module mspc_v_alu_issue
  import mspc_v_pkg::*;
#(
  parameter int TAG_W         = 5,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [63:0]      in_opa,
  input  logic [63:0]      in_opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      alu_inpa,
  output logic [63:0]      alu_inpb,
  output logic [3:0]       alu_sel,
  input  logic [63:0]      alu_numoutp,
  input  logic             alu_booloutp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [1:0]       out_kind,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [63:0]      opa_q, opa_d;
  logic [63:0]      opb_q, opb_d;
  logic [63:0]      out_data_q, out_data_d;
  kind_e            out_kind_q, out_kind_d;
  logic             out_valid_q, out_valid_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  assign in_ready = (state_q == ST_IDLE) && !flush;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    sel_d       = sel_q;
    alu_sel_d   = alu_sel_q;
    tag_d       = tag_q;
    out_tag_d   = out_tag_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    out_data_d  = out_data_q;
    out_kind_d  = out_kind_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    op_count_d  = op_count_q;

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      alu_sel_d   = NOP_SEL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sel_d = in_sel;
            tag_d = in_tag;
            opa_d = in_opa;
            opb_d = is_shift(in_sel) ? {58'b0, in_opb[5:0]} : in_opb;
            if (op_class(in_sel) == KIND_NOP) begin
              out_data_d  = '0;
              out_kind_d  = KIND_NOP;
              out_tag_d   = in_tag;
              out_valid_d = 1'b1;
              state_d     = ST_RESULT;
            end else begin
              state_d = ST_PARK;
            end
          end
        end
        ST_PARK: begin
          alu_sel_d = sel_q;
          cnt_d     = SC_W'(SETTLE_CYCLES - 1);
          state_d   = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            out_data_d  = (op_class(sel_q) == KIND_BOOL) ? {63'b0, alu_booloutp}
                                                         : alu_numoutp;
            out_kind_d  = op_class(sel_q);
            out_tag_d   = tag_q;
            out_valid_d = 1'b1;
            alu_sel_d   = NOP_SEL;
            state_d     = ST_RESULT;
          end else begin
            cnt_d = cnt_q - SC_W'(1);
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            op_count_d  = op_count_q + CNT_W'(1);
            alu_sel_d   = NOP_SEL;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= NOP_SEL;
      alu_sel_q   <= NOP_SEL;
      tag_q       <= '0;
      out_tag_q   <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      out_data_q  <= '0;
      out_kind_q  <= KIND_NUM;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      alu_sel_q   <= alu_sel_d;
      tag_q       <= tag_d;
      out_tag_q   <= out_tag_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      out_data_q  <= out_data_d;
      out_kind_q  <= out_kind_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_inpa  = opa_q;
  assign alu_inpb  = opb_q;
  assign alu_sel   = alu_sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_kind  = out_kind_q;
  assign out_tag   = out_tag_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

endmodule
